// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundles the instruction-memory req/ack bus, the execute-stage
// redirect/halt controls and the decode valid/ready handshake of the fetch sequencer.
//   master modport: the fetch sequencer (drives imem_req/addr, if_*, fetch_timeout)
//   slave modport : the environment (memory, execute, decode)
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halt;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               if_ready;
  logic               fetch_timeout;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_timeout,
    input  imem_ack, imem_rdata, redirect, redirect_pc, halt, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_timeout,
    output imem_ack, imem_rdata, redirect, redirect_pc, halt, if_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller. Holds the PC, issues one req/ack fetch at a
// time, buffers the returned word for decode behind valid/ready, applies branch redirects and
// drops fetches invalidated in flight. A sticky watchdog flags fetches that wait too long.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - fetch_sequencer_if.master (imem req/addr/ack/rdata, redirect/redirect_pc/halt,
//           if_valid/if_instr/if_pc/if_ready, fetch_timeout)
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 1024
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e             r_state, w_state_d;
  logic [ADDR_W-1:0]  r_pc, w_pc_d;
  logic [ADDR_W-1:0]  r_req_addr, w_req_addr_d;
  logic               r_if_valid, w_if_valid_d;
  logic [INSTR_W-1:0] r_if_instr, w_if_instr_d;
  logic [ADDR_W-1:0]  r_if_pc, w_if_pc_d;
  logic [CNT_W-1:0]   r_wait_cnt, w_wait_cnt_d;
  logic               r_timeout, w_timeout_d;
  logic [ADDR_W-1:0]  w_target;
  logic               w_req;
  logic               w_enter_fetch;

  // DRAIN keeps the stale request on the bus until the memory completes it.
  assign w_req    = (r_state == StFetch) || (r_state == StDrain);
  assign w_target = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_req_addr_d = r_req_addr;
    w_if_valid_d = r_if_valid;
    w_if_instr_d = r_if_instr;
    w_if_pc_d    = r_if_pc;

    unique case (r_state)
      StIdle: begin
        if (bus.redirect) w_pc_d = w_target;
        if (!bus.halt) w_state_d = StFetch;
      end
      StFetch: begin
        if (bus.imem_ack) begin
          if (bus.redirect) begin
            w_pc_d    = w_target;
            w_state_d = bus.halt ? StIdle : StFetch;
          end else begin
            w_if_valid_d = 1'b1;
            w_if_instr_d = bus.imem_rdata;
            w_if_pc_d    = r_req_addr;
            w_pc_d       = r_req_addr + ADDR_W'(4);
            w_state_d    = StHold;
          end
        end else if (bus.redirect) begin
          w_pc_d    = w_target;
          w_state_d = StDrain;
        end
      end
      StHold: begin
        if (bus.redirect) begin
          w_if_valid_d = 1'b0;
          w_pc_d       = w_target;
          w_state_d    = bus.halt ? StIdle : StFetch;
        end else if (bus.if_ready) begin
          w_if_valid_d = 1'b0;
          w_state_d    = bus.halt ? StIdle : StFetch;
        end
      end
      StDrain: begin
        if (bus.redirect) w_pc_d = w_target;
        // The stale word is discarded; only completion matters here.
        if (bus.imem_ack) w_state_d = bus.halt ? StIdle : StFetch;
      end
      default: w_state_d = StIdle;
    endcase

    // FETCH -> FETCH through ack+redirect is a fresh entry and must re-arm the address too.
    w_enter_fetch = (w_state_d == StFetch) && ((r_state != StFetch) || bus.imem_ack);
    if (w_enter_fetch) w_req_addr_d = w_pc_d;
  end

  // Watchdog: count unanswered request cycles, saturating at TIMEOUT.
  always_comb begin
    w_wait_cnt_d = r_wait_cnt;
    if (bus.imem_ack) begin
      w_wait_cnt_d = '0;
    end else if (w_req && (r_wait_cnt != TIMEOUT_C)) begin
      w_wait_cnt_d = r_wait_cnt + CNT_W'(1);
    end
    w_timeout_d = r_timeout || ((TIMEOUT != 0) && (w_wait_cnt_d == TIMEOUT_C));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_req_addr <= w_req_addr_d;
      r_if_valid <= w_if_valid_d;
      r_if_instr <= w_if_instr_d;
      r_if_pc    <= w_if_pc_d;
      r_wait_cnt <= w_wait_cnt_d;
      r_timeout  <= w_timeout_d;
    end
  end

  assign bus.imem_req      = w_req;
  assign bus.imem_addr     = r_req_addr;
  assign bus.if_valid      = r_if_valid;
  assign bus.if_instr      = r_if_instr;
  assign bus.if_pc         = r_if_pc;
  assign bus.fetch_timeout = r_timeout;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios followed by randomized stimulus, every cycle compared
// against a transaction-level model of the fetch unit (outstanding fetch, poisoned flag,
// decode buffer, watchdog count).
module tb_fetch_sequencer;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 32;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_sequencer #(
    .ADDR_W  (AW),
    .INSTR_W (IW),
    .RESET_PC(64'h0),
    .TIMEOUT (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [AW-1:0] m_pc, m_addr, m_ipc;
  logic [IW-1:0] m_instr;
  bit            m_out;    // a fetch is outstanding on the bus
  bit            m_stale;  // outstanding fetch was invalidated by a redirect
  bit            m_have;   // word buffered for decode
  bit            m_to;
  int unsigned   m_wait;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc = '0; m_addr = '0; m_ipc = '0; m_instr = '0;
    m_out = 0; m_stale = 0; m_have = 0; m_to = 0; m_wait = 0;
  endfunction

  // Start the next fetch from the current PC unless halted.
  function automatic void model_launch();
    if (!bus.halt) begin
      m_out   = 1;
      m_stale = 0;
      m_addr  = m_pc;
    end
  endfunction

  function automatic void model_step();
    logic [AW-1:0] tgt;
    bit was_out;
    tgt     = bus.redirect_pc & ~64'h3;
    was_out = m_out;
    if (m_out && !m_stale) begin
      if (bus.imem_ack) begin
        m_out = 0;
        if (bus.redirect) begin
          m_pc = tgt;
          model_launch();
        end else begin
          m_have  = 1;
          m_instr = bus.imem_rdata;
          m_ipc   = m_addr;
          m_pc    = m_addr + 64'd4;
        end
      end else if (bus.redirect) begin
        m_pc    = tgt;
        m_stale = 1;
      end
    end else if (m_out) begin
      if (bus.redirect) m_pc = tgt;
      if (bus.imem_ack) begin
        m_out   = 0;
        m_stale = 0;
        model_launch();
      end
    end else if (m_have) begin
      if (bus.redirect) begin
        m_have = 0;
        m_pc   = tgt;
        model_launch();
      end else if (bus.if_ready) begin
        m_have = 0;
        model_launch();
      end
    end else begin
      if (bus.redirect) m_pc = tgt;
      model_launch();
    end
    if (bus.imem_ack) m_wait = 0;
    else if (was_out && m_wait < TO) m_wait++;
    if (TO != 0 && m_wait >= TO) m_to = 1;
  endfunction

  task automatic compare_all();
    check_eq("imem_req", bus.imem_req, m_out);
    if (m_out) check_eq("imem_addr", bus.imem_addr, m_addr);
    check_eq("if_valid", bus.if_valid, m_have);
    if (m_have) begin
      check_eq("if_instr", bus.if_instr, m_instr);
      check_eq("if_pc", bus.if_pc, m_ipc);
    end
    check_eq("fetch_timeout", bus.fetch_timeout, m_to);
  endtask

  // Drive one cycle of inputs (called just after a falling edge), clock, check.
  task automatic cycle(input bit want_ack, input logic [IW-1:0] rd, input bit redir,
                       input logic [AW-1:0] rpc, input bit halt, input bit ready);
    bus.imem_ack    = want_ack && m_out;
    bus.imem_rdata  = rd;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.halt        = halt;
    bus.if_ready    = ready;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset landing between clock edges.
  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("async_req_drop", bus.imem_req, 1'b0);
    check_eq("async_valid_drop", bus.if_valid, 1'b0);
    check_eq("async_timeout_clr", bus.fetch_timeout, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    reset            = 1'b1;
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = '0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = '0;
    bus.halt         = 1'b0;
    bus.if_ready     = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_req", bus.imem_req, 1'b0);
    check_eq("rst_valid", bus.if_valid, 1'b0);
    check_eq("rst_instr", bus.if_instr, 0);
    check_eq("rst_pc", bus.if_pc, 0);
    check_eq("rst_timeout", bus.fetch_timeout, 1'b0);
    reset = 1'b0;

    // Sequential fetches 0,4,8 with ready decode.
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, 0, '0, 0, 1);
      check_eq("t1_addr", bus.imem_addr, 64'(4 * i));
      cycle(1, 32'hA000_0000 + 32'(i), 0, '0, 0, 1);
      check_eq("t1_if_pc", bus.if_pc, 64'(4 * i));
      check_eq("t1_if_instr", bus.if_instr, 32'hA000_0000 + 32'(i));
    end

    // Decode stalls for 5 cycles: output stable, no request.
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, 0, '0, 0, 0);
      check_eq("t2_hold_req", bus.imem_req, 1'b0);
      check_eq("t2_hold_pc", bus.if_pc, 64'h8);
    end
    cycle(0, '0, 0, '0, 0, 1);
    check_eq("t2_next_addr", bus.imem_addr, 64'hC);

    // Redirect while the fetch at 0xC waits: stale request held, word dropped.
    cycle(0, '0, 1, 64'h100, 0, 1);
    check_eq("t3_drain_addr", bus.imem_addr, 64'hC);
    cycle(0, '0, 0, '0, 0, 1);
    cycle(0, '0, 0, '0, 0, 1);
    cycle(1, 32'hDEAD_BEEF, 0, '0, 0, 1);
    check_eq("t3_no_valid", bus.if_valid, 1'b0);
    check_eq("t3_new_addr", bus.imem_addr, 64'h100);

    // Redirect in HOLD with unaligned target; redirect coincident with ack.
    cycle(1, 32'h1111_1111, 0, '0, 0, 0);
    cycle(0, '0, 1, 64'h203, 0, 1);
    check_eq("t4_valid_fall", bus.if_valid, 1'b0);
    check_eq("t4_aligned", bus.imem_addr, 64'h200);
    cycle(1, 32'h2222_2222, 1, 64'h300, 0, 1);
    check_eq("t4_ack_drop", bus.if_valid, 1'b0);
    check_eq("t4_addr300", bus.imem_addr, 64'h300);

    // Halt during FETCH: word still delivered, then idle until released.
    cycle(0, '0, 0, '0, 1, 0);
    cycle(1, 32'h3333_3333, 0, '0, 1, 0);
    check_eq("t5_delivered", bus.if_pc, 64'h300);
    cycle(0, '0, 0, '0, 1, 1);
    check_eq("t5_idle_req", bus.imem_req, 1'b0);
    cycle(0, '0, 0, '0, 1, 1);
    cycle(0, '0, 0, '0, 0, 1);
    check_eq("t5_resume", bus.imem_addr, 64'h304);

    // Watchdog: 4 unanswered request cycles.
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, '0, 0, 1);
    check_eq("t6_wd_early", bus.fetch_timeout, 1'b0);
    cycle(0, '0, 0, '0, 0, 1);
    check_eq("t6_wd_set", bus.fetch_timeout, 1'b1);
    cycle(1, 32'h4444_4444, 0, '0, 0, 0);
    check_eq("t6_wd_sticky", bus.fetch_timeout, 1'b1);

    // PC wrap from the top of the address space.
    cycle(0, '0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1);
    check_eq("t6_top_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1, 32'h5555_5555, 0, '0, 0, 0);
    cycle(0, '0, 0, '0, 0, 1);
    check_eq("t6_wrap", bus.imem_addr, 64'h0);

    // Async reset mid-FETCH.
    cycle(0, '0, 1, 64'h440, 0, 1);
    cycle(1, '0, 0, '0, 0, 1);
    pulse_reset();
    cycle(0, '0, 0, '0, 0, 1);
    check_eq("t6_reset_pc", bus.imem_addr, 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] rpc;
      if ($urandom_range(0, 7) == 0) rpc = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)};
      else rpc = {$urandom, $urandom};
      cycle($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 9) == 0, rpc,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
      if (i % 500 == 499) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
